vector_mac_engine: RTL

Sequential, parametrised successor to the combinational vector multiplier. Computes the matrix product R = F × W, where F is FEATURE_ROWS × FEATURE_COLS and W is WEIGHT_ROWS × WEIGHT_COLS. It streams one inner-dimension step per accepted beat and accumulates outer products in a FEATURE_ROWS × WEIGHT_COLS accumulator array. Results are scaled and narrowed before a valid/ready hand-off to the downstream layer. It sits between the scratchpad (weight source) and the feature buffer.

---
 rtl/vmac_pkg.sv | 36 +++
 rtl/vmac_lane.sv | 65 ++++++
 rtl/vector_mac_engine.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/vmac_pkg.sv
// Shared types and helpers for the vector MAC engine.
package vmac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } vmac_state_t;

  // Widest accumulator the scaling helper has to handle.
  localparam int SCALE_WIDTH = 64;

  // Accumulator width that can never overflow for a k-deep dot product.
  function automatic int acc_width(input int fw, input int ww, input int k);
    return fw + ww + $clog2(k);
  endfunction

  // Right-shift an accumulator, then saturate or wrap it to ow bits.
  function automatic logic [SCALE_WIDTH-1:0] scale_sat(
    input logic [SCALE_WIDTH-1:0] acc,
    input logic [7:0]             shift,
    input logic                   sat_en,
    input int                     ow
  );
    logic [SCALE_WIDTH-1:0] shifted;
    logic [SCALE_WIDTH-1:0] max_val;
    shifted = acc >> shift;
    max_val = (64'd1 << ow) - 64'd1;
    if (sat_en && (shifted > max_val)) begin
      return max_val;
    end else begin
      return shifted & max_val;
    end
  endfunction

endpackage

// File: rtl/vmac_lane.sv
// One result row: WEIGHT_COLS multipliers and accumulators fed by a single
// feature scalar. result_next is the scaled value of the accumulators as
// they will be after this cycle, so the top can capture it on the last beat.
module vmac_lane
  import vmac_pkg::*;
#(
  parameter int FEATURE_WIDTH = 8,
  parameter int WEIGHT_WIDTH  = 5,
  parameter int WEIGHT_COLS   = 3,
  parameter int ACC_WIDTH     = 20,
  parameter int SHIFT_WIDTH   = 5
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        clear,
  input  logic                                        enable,
  input  logic [FEATURE_WIDTH-1:0]                    feature,
  input  logic [WEIGHT_COLS-1:0][WEIGHT_WIDTH-1:0]    weight_row,
  input  logic [SHIFT_WIDTH-1:0]                      shift,
  input  logic                                        sat_en,
  output logic [WEIGHT_COLS-1:0][FEATURE_WIDTH-1:0]   result_next
);

  localparam int PROD_WIDTH = FEATURE_WIDTH + WEIGHT_WIDTH;

  logic [ACC_WIDTH-1:0]  acc_q  [WEIGHT_COLS];
  logic [ACC_WIDTH-1:0]  acc_d  [WEIGHT_COLS];
  logic [PROD_WIDTH-1:0] prod_s [WEIGHT_COLS];

  // Next accumulator value: clear on start, add the product on a beat, else hold.
  always_comb begin
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      prod_s[c] = PROD_WIDTH'(feature) * PROD_WIDTH'(weight_row[c]);
      if (clear) begin
        acc_d[c] = '0;
      end else if (enable) begin
        acc_d[c] = acc_q[c] + ACC_WIDTH'(prod_s[c]);
      end else begin
        acc_d[c] = acc_q[c];
      end
    end
  end

  // Scaled view of the next accumulator values.
  always_comb begin
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      result_next[c] = FEATURE_WIDTH'(scale_sat(SCALE_WIDTH'(acc_d[c]), 8'(shift),
                                                sat_en, FEATURE_WIDTH));
    end
  end

  // Accumulator registers; reset discards any partial sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < WEIGHT_COLS; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < WEIGHT_COLS; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

endmodule

// File: rtl/vector_mac_engine.sv
// Sequential matrix product R = F x W, one inner-dimension step per beat.
// Owns the control FSM, beat counter, sampled mode and both handshakes;
// the per-row arithmetic lives in vmac_lane.
module vector_mac_engine
  import vmac_pkg::*;
#(
  parameter int WEIGHT_WIDTH  = 5,
  parameter int FEATURE_WIDTH = 8,
  parameter int FEATURE_ROWS  = 6,
  parameter int FEATURE_COLS  = 96,
  parameter int WEIGHT_ROWS   = 96,
  parameter int WEIGHT_COLS   = 3,
  localparam int ACC_WIDTH    = acc_width(FEATURE_WIDTH, WEIGHT_WIDTH, FEATURE_COLS),
  localparam int SHIFT_WIDTH  = $clog2(ACC_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [SHIFT_WIDTH-1:0]   out_shift,
  input  logic                     sat_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FEATURE_WIDTH-1:0] feature_col [0:FEATURE_ROWS-1],
  input  logic [WEIGHT_WIDTH-1:0]  weight_row  [0:WEIGHT_COLS-1],
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FEATURE_WIDTH-1:0] result [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1]
);

  // Inner dimension; FEATURE_COLS and WEIGHT_ROWS are required to match.
  localparam int K_DIM     = (FEATURE_COLS < WEIGHT_ROWS) ? FEATURE_COLS : WEIGHT_ROWS;
  localparam int CNT_WIDTH = (K_DIM > 1) ? $clog2(K_DIM) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(K_DIM - 1);

  vmac_state_t state_q, state_d;

  logic [CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic                   sat_q, sat_d;

  logic [WEIGHT_COLS-1:0][FEATURE_WIDTH-1:0] result_q      [FEATURE_ROWS];
  logic [WEIGHT_COLS-1:0][FEATURE_WIDTH-1:0] result_d      [FEATURE_ROWS];
  logic [WEIGHT_COLS-1:0][FEATURE_WIDTH-1:0] lane_result_s [FEATURE_ROWS];
  logic [WEIGHT_COLS-1:0][WEIGHT_WIDTH-1:0]  weight_packed_s;

  logic in_ready_s, busy_s, out_valid_s;
  logic start_s, beat_s, last_beat_s;

  // Handshake qualifiers: start only counts in IDLE, a beat only on in_valid & in_ready.
  always_comb begin
    start_s     = (state_q == IDLE) && start;
    beat_s      = in_ready_s && in_valid;
    last_beat_s = beat_s && (beat_cnt_q == LAST_BEAT);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = ACCUM;
        else       state_d = IDLE;
      end
      ACCUM: begin
        if (last_beat_s) state_d = DONE;
        else             state_d = ACCUM;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output decode; depends on the state register only.
  always_comb begin
    in_ready_s  = 1'b0;
    busy_s      = 1'b0;
    out_valid_s = 1'b0;
    case (state_q)
      IDLE: begin
        busy_s = 1'b0;
      end
      ACCUM: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
      DONE: begin
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Beat counter and mode sampling: reload on start, count on each beat.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    shift_d    = shift_q;
    sat_d      = sat_q;
    if (start_s) begin
      beat_cnt_d = '0;
      shift_d    = out_shift;
      sat_d      = sat_en;
    end else if (beat_s) begin
      beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // Capture the scaled result on the same edge that takes the last beat.
  always_comb begin
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      if (last_beat_s) begin
        result_d[r] = lane_result_s[r];
      end else begin
        result_d[r] = result_q[r];
      end
    end
  end

  // Datapath control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      shift_q    <= '0;
      sat_q      <= 1'b0;
      for (int r = 0; r < FEATURE_ROWS; r++) begin
        result_q[r] <= '0;
      end
    end else begin
      beat_cnt_q <= beat_cnt_d;
      shift_q    <= shift_d;
      sat_q      <= sat_d;
      for (int r = 0; r < FEATURE_ROWS; r++) begin
        result_q[r] <= result_d[r];
      end
    end
  end

  // Repack the weight row so every lane sees it as one vector.
  always_comb begin
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      weight_packed_s[c] = weight_row[c];
    end
  end

  for (genvar r = 0; r < FEATURE_ROWS; r++) begin : g_lane
    vmac_lane #(
      .FEATURE_WIDTH (FEATURE_WIDTH),
      .WEIGHT_WIDTH  (WEIGHT_WIDTH),
      .WEIGHT_COLS   (WEIGHT_COLS),
      .ACC_WIDTH     (ACC_WIDTH),
      .SHIFT_WIDTH   (SHIFT_WIDTH)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (start_s),
      .enable      (beat_s),
      .feature     (feature_col[r]),
      .weight_row  (weight_packed_s),
      .shift       (shift_q),
      .sat_en      (sat_q),
      .result_next (lane_result_s[r])
    );
  end

  // Drive the output ports from registered state.
  always_comb begin
    in_ready  = in_ready_s;
    busy      = busy_s;
    out_valid = out_valid_s;
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      for (int c = 0; c < WEIGHT_COLS; c++) begin
        result[r][c] = result_q[r][c];
      end
    end
  end

endmodule
